// File: rtl/fht_frame_sched.sv
// Frame scheduler around the FHT core: loads one frame into the four interleaved banks,
// kicks the core, then streams the result back out of the bank set the core reports.
module fht_frame_sched #(
  parameter int unsigned A_BIT   = 8,
  parameter int unsigned D_BIT   = 16,
  parameter int unsigned TIMEOUT = 8192
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic [D_BIT-1:0]   iDATA,
  input  logic               iVALID,
  output logic               oREADY,
  output logic               oSTART,
  input  logic               iFHT_RDY,
  input  logic               iRES_SET,
  output logic               oBANK_OWN,
  output logic               oBANK_SET,
  output logic [3:0]         oBANK_WE,
  output logic [A_BIT-1:0]   oBANK_ADDR,
  output logic [D_BIT-1:0]   oBANK_D,
  input  logic [4*D_BIT-1:0] iBANK_Q,
  output logic [D_BIT-1:0]   oDATA,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oBUSY,
  output logic               oERR
);

  localparam int unsigned IW = A_BIT + 2;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IdxMax   = {IW{1'b1}};
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    StLoad,
    StKick,
    StWait,
    StRun,
    StUAddr,
    StUCap,
    StUHold
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, idx_inc;
  logic [TW-1:0]      timer_q, timer_d, timer_inc;
  logic               ready_q, ready_d;
  logic               start_q, start_d;
  logic               own_q, own_d;
  logic               set_q, set_d;
  logic [3:0]         we_q, we_d;
  logic [A_BIT-1:0]   addr_q, addr_d;
  logic [D_BIT-1:0]   bd_q, bd_d;
  logic [D_BIT-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [D_BIT-1:0]   rd_word;

  assign idx_inc   = idx_q + IW'(1);
  assign timer_inc = timer_q + TW'(1);

  // Point k lives in bank k[1:0]; select that lane of the registered bank output.
  always_comb begin
    rd_word = '0;
    case (idx_q[1:0])
      2'd0:    rd_word = iBANK_Q[0*D_BIT +: D_BIT];
      2'd1:    rd_word = iBANK_Q[1*D_BIT +: D_BIT];
      2'd2:    rd_word = iBANK_Q[2*D_BIT +: D_BIT];
      default: rd_word = iBANK_Q[3*D_BIT +: D_BIT];
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    ready_d = ready_q;
    start_d = 1'b0;
    own_d   = own_q;
    set_d   = set_q;
    we_d    = '0;
    addr_d  = addr_q;
    bd_d    = bd_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;

    unique case (state_q)
      StLoad: begin
        ready_d = 1'b1;
        set_d   = 1'b0;
        if (iVALID && ready_q) begin
          we_d   = 4'b0001 << idx_q[1:0];
          addr_d = idx_q[IW-1:2];
          bd_d   = iDATA;
          idx_d  = idx_inc;
          err_d  = 1'b0;
          if (idx_q == IdxMax) begin
            ready_d = 1'b0;
            state_d = StKick;
          end
        end
      end
      StKick: begin
        start_d = 1'b1;
        own_d   = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = '0;
        state_d = StRun;
      end
      StRun: begin
        timer_d = timer_inc;
        if (iFHT_RDY) begin
          set_d   = iRES_SET;
          own_d   = 1'b1;
          addr_d  = idx_q[IW-1:2];
          state_d = StUAddr;
        end else if (timer_inc == TimerMax) begin
          err_d   = 1'b1;
          own_d   = 1'b1;
          ready_d = 1'b1;
          addr_d  = '0;
          state_d = StLoad;
        end
      end
      // Address was presented on entry; the bank registers it at the end of this cycle.
      StUAddr: state_d = StUCap;
      StUCap: begin
        data_d  = rd_word;
        valid_d = 1'b1;
        state_d = StUHold;
      end
      StUHold: begin
        if (iREADY) begin
          valid_d = 1'b0;
          idx_d   = idx_inc;
          if (idx_q == IdxMax) begin
            set_d   = 1'b0;
            ready_d = 1'b1;
            addr_d  = '0;
            state_d = StLoad;
          end else begin
            addr_d  = idx_inc[IW-1:2];
            state_d = StUAddr;
          end
        end
      end
      default: state_d = StLoad;
    endcase

    busy_d = (state_d != StLoad);
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= StLoad;
      idx_q   <= '0;
      timer_q <= '0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      own_q   <= 1'b1;
      set_q   <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      bd_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      ready_q <= ready_d;
      start_q <= start_d;
      own_q   <= own_d;
      set_q   <= set_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      bd_q    <= bd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign oREADY     = ready_q;
  assign oSTART     = start_q;
  assign oBANK_OWN  = own_q;
  assign oBANK_SET  = set_q;
  assign oBANK_WE   = we_q;
  assign oBANK_ADDR = addr_q;
  assign oBANK_D    = bd_q;
  assign oDATA      = data_q;
  assign oVALID     = valid_q;
  assign oBUSY      = busy_q;
  assign oERR       = err_q;

endmodule
